// File: rtl/irrigation_level_ctrl.sv
// rtl/irrigation_level_ctrl.sv - tank level / sprinkler / drip controller with mm:ss BCD countdown
// Optional IRRIG_PAUSE_EN adds a pause input that freezes the countdown and level.
module irrigation_level_ctrl #(
    parameter int ASP_PERIOD  = 5,
    parameter int GOT_PERIOD  = 10,
    parameter int SEC_PER_MIN = 60
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       tick,
    input  logic       fill,
    input  logic       asp_req,
    input  logic       got_req,
`ifdef IRRIG_PAUSE_EN
    input  logic       pause,
`endif
    output logic       H,
    output logic       M,
    output logic       L,
    output logic       Bs,
    output logic       Vs,
    output logic       Error,
    output logic [3:0] bcd_10m,
    output logic [3:0] bcd_m,
    output logic [3:0] bcd_10s,
    output logic [3:0] bcd_s
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ASP   = 3'd1,
        ST_GOT   = 3'd2,
        ST_ERR   = 3'd3,
        ST_EMPTY = 3'd4
    } state_t;

    localparam logic [3:0] ASP_10M = 4'((ASP_PERIOD - 1) / 10);
    localparam logic [3:0] ASP_M   = 4'((ASP_PERIOD - 1) % 10);
    localparam logic [3:0] GOT_10M = 4'((GOT_PERIOD - 1) / 10);
    localparam logic [3:0] GOT_M   = 4'((GOT_PERIOD - 1) % 10);
    localparam logic [3:0] SEC_10S = 4'((SEC_PER_MIN - 1) / 10);
    localparam logic [3:0] SEC_S   = 4'((SEC_PER_MIN - 1) % 10);

    localparam logic [15:0] ASP_LOAD = {ASP_10M, ASP_M, SEC_10S, SEC_S};
    localparam logic [15:0] GOT_LOAD = {GOT_10M, GOT_M, SEC_10S, SEC_S};

    state_t      r_state, w_state;
    logic [1:0]  r_lvl, w_lvl;
    logic [15:0] r_cnt, w_cnt;
    logic        w_tick;
    logic        w_req;
    logic        w_zero;
    logic [15:0] w_reload;

`ifdef IRRIG_PAUSE_EN
    assign w_tick = tick & ~pause;
`else
    assign w_tick = tick;
`endif

    assign w_zero   = (r_cnt == 16'h0000);
    assign w_req    = (r_state == ST_ASP) ? asp_req : got_req;
    assign w_reload = (r_state == ST_ASP) ? ASP_LOAD : GOT_LOAD;

    // BCD mm:ss decrement; seconds borrow wraps to SEC_PER_MIN-1. Never called at 00:00.
    function automatic logic [15:0] bcd_dec(input logic [15:0] c);
        logic [15:0] n;
        n = c;
        if (c[3:0] != 4'd0) begin
            n[3:0] = c[3:0] - 4'd1;
        end else if (c[7:4] != 4'd0) begin
            n[7:4] = c[7:4] - 4'd1;
            n[3:0] = 4'd9;
        end else begin
            n[7:0] = {SEC_10S, SEC_S};
            if (c[11:8] != 4'd0) begin
                n[11:8] = c[11:8] - 4'd1;
            end else begin
                n[15:12] = c[15:12] - 4'd1;
                n[11:8]  = 4'd9;
            end
        end
        return n;
    endfunction

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_lvl   <= 2'd3;
            r_cnt   <= 16'h0000;
        end else begin
            r_state <= w_state;
            r_lvl   <= w_lvl;
            r_cnt   <= w_cnt;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_lvl   = (fill && r_state != ST_ERR) ? 2'd3 : r_lvl;
        if (asp_req && got_req) begin
            w_state = ST_ERR;
            w_cnt   = 16'h0000;
        end else begin
            case (r_state)
                ST_ERR: begin
                    if (!asp_req && !got_req)
                        w_state = (r_lvl != 2'd0) ? ST_IDLE : ST_EMPTY;
                end
                ST_IDLE: begin
                    if (r_lvl == 2'd0) begin
                        w_state = ST_EMPTY;
                    end else if (asp_req) begin
                        w_state = ST_ASP;
                        w_cnt   = ASP_LOAD;
                    end else if (got_req) begin
                        w_state = ST_GOT;
                        w_cnt   = GOT_LOAD;
                    end
                end
                ST_ASP, ST_GOT: begin
                    if (!w_req) begin
                        w_state = ST_IDLE;
                        w_cnt   = 16'h0000;
                    end else if (w_tick) begin
                        if (!w_zero) begin
                            w_cnt = bcd_dec(r_cnt);
                        end else if (fill) begin
                            // refill wins over the drop, but the period still restarts
                            w_cnt = w_reload;
                        end else if (r_lvl == 2'd1) begin
                            w_lvl   = 2'd0;
                            w_state = ST_EMPTY;
                            w_cnt   = 16'h0000;
                        end else begin
                            w_lvl = r_lvl - 2'd1;
                            w_cnt = w_reload;
                        end
                    end
                end
                ST_EMPTY: begin
                    if (r_lvl != 2'd0)
                        w_state = ST_IDLE;
                end
                default: begin
                    w_state = ST_IDLE;
                    w_cnt   = 16'h0000;
                end
            endcase
        end
    end

    assign H       = (r_lvl == 2'd3);
    assign M       = (r_lvl >= 2'd2);
    assign L       = (r_lvl != 2'd0);
    assign Bs      = (r_state == ST_ASP);
    assign Vs      = (r_state == ST_GOT);
    assign Error   = (r_state == ST_ERR);
    assign bcd_10m = r_cnt[15:12];
    assign bcd_m   = r_cnt[11:8];
    assign bcd_10s = r_cnt[7:4];
    assign bcd_s   = r_cnt[3:0];

endmodule

// File: tb/tb_irrigation_level_ctrl.sv
// tb/tb_irrigation_level_ctrl.sv - self-checking bench for irrigation_level_ctrl
module tb_irrigation_level_ctrl;

    localparam int ASP = 5;
    localparam int GOT = 10;
    localparam int SPM = 2;

    localparam int M_IDLE  = 0;
    localparam int M_ASP   = 1;
    localparam int M_GOT   = 2;
    localparam int M_ERR   = 3;
    localparam int M_EMPTY = 4;

    logic clock = 1'b0;
    logic rst = 1'b0, tick = 1'b0, fill = 1'b0, asp_req = 1'b0, got_req = 1'b0, pause = 1'b0;
    logic H, M, L, Bs, Vs, Error;
    logic [3:0] bcd_10m, bcd_m, bcd_10s, bcd_s;
    logic [21:0] dut_vec;

    int checks = 0;
    int errors = 0;

    // reference state: level, operating mode, seconds remaining until the next drop
    int m_lvl  = 3;
    int m_mode = M_IDLE;
    int m_rem  = 0;

    always #5 clock = ~clock;

    irrigation_level_ctrl #(
        .ASP_PERIOD (ASP),
        .GOT_PERIOD (GOT),
        .SEC_PER_MIN(SPM)
    ) dut (
        .clock  (clock),
        .rst    (rst),
        .tick   (tick),
        .fill   (fill),
        .asp_req(asp_req),
        .got_req(got_req),
`ifdef IRRIG_PAUSE_EN
        .pause  (pause),
`endif
        .H      (H),
        .M      (M),
        .L      (L),
        .Bs     (Bs),
        .Vs     (Vs),
        .Error  (Error),
        .bcd_10m(bcd_10m),
        .bcd_m  (bcd_m),
        .bcd_10s(bcd_10s),
        .bcd_s  (bcd_s)
    );

    assign dut_vec = {H, M, L, Bs, Vs, Error, bcd_10m, bcd_m, bcd_10s, bcd_s};

    function automatic logic [21:0] exp_vec();
        int mn, sc;
        mn = m_rem / SPM;
        sc = m_rem % SPM;
        return {m_lvl == 3, m_lvl >= 2, m_lvl >= 1,
                m_mode == M_ASP, m_mode == M_GOT, m_mode == M_ERR,
                4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    task automatic model(input logic r, t, f, a, g, p);
        int  nl, per;
        logic tk;
`ifdef IRRIG_PAUSE_EN
        tk = t && !p;
`else
        tk = t;
`endif
        per = (m_mode == M_ASP) ? ASP : GOT;
        if (r) begin
            m_lvl = 3; m_mode = M_IDLE; m_rem = 0;
        end else begin
            nl = (f && m_mode != M_ERR) ? 3 : m_lvl;
            if (a && g) begin
                m_mode = M_ERR; m_rem = 0;
            end else if (m_mode == M_ERR) begin
                if (!a && !g) m_mode = (m_lvl > 0) ? M_IDLE : M_EMPTY;
            end else if (m_mode == M_IDLE) begin
                if (m_lvl == 0) m_mode = M_EMPTY;
                else if (a) begin m_mode = M_ASP; m_rem = ASP * SPM - 1; end
                else if (g) begin m_mode = M_GOT; m_rem = GOT * SPM - 1; end
            end else if (m_mode == M_ASP || m_mode == M_GOT) begin
                if (!((m_mode == M_ASP) ? a : g)) begin
                    m_mode = M_IDLE; m_rem = 0;
                end else if (tk) begin
                    if (m_rem > 0) m_rem = m_rem - 1;
                    else begin
                        if (!f) nl = m_lvl - 1;
                        if (nl == 0) begin m_mode = M_EMPTY; m_rem = 0; end
                        else m_rem = per * SPM - 1;
                    end
                end
            end else if (m_mode == M_EMPTY) begin
                if (m_lvl > 0) m_mode = M_IDLE;
            end
            m_lvl = nl;
        end
    endtask

    task automatic step(input logic r, t, f, a, g, p);
        rst = r; tick = t; fill = f; asp_req = a; got_req = g; pause = p;
        @(posedge clock);
        model(r, t, f, a, g, p);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0);
        checks++;
        if (dut_vec !== 22'b111000_0000_0000_0000_0000) begin
            errors++; $display("FAIL reset_const got %h exp %h", dut_vec, 22'b111000_0000_0000_0000_0000);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL reset_model got %h exp %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_asp();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        checks++;
        if ({Bs, bcd_10m, bcd_m, bcd_10s, bcd_s} !== 17'h1_0401) begin
            errors++; $display("FAIL asp_entry got %h exp %h", {Bs, bcd_10m, bcd_m, bcd_10s, bcd_s}, 17'h1_0401);
        end
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 1, 0, 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL asp_tick%0d got %h exp %h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if ({H, M, L, bcd_10m, bcd_m, bcd_10s, bcd_s} !== 19'b011_0000_0100_0000_0001) begin
            errors++; $display("FAIL asp_drop got %h exp %h", {H, M, L, bcd_10m, bcd_m, bcd_10s, bcd_s}, 19'b011_0000_0100_0000_0001);
        end
    endtask

    task automatic test_got_empty();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 60; i++) begin
            step(0, 1, 0, 0, 1, 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL got_tick%0d got %h exp %h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if ({L, Vs} !== 2'b00) begin
            errors++; $display("FAIL got_empty got %b exp %b", {L, Vs}, 2'b00);
        end
        step(0, 0, 1, 0, 1, 0);
        checks++;
        if ({H, M, L, Vs} !== 4'b1110) begin
            errors++; $display("FAIL got_fill got %b exp %b", {H, M, L, Vs}, 4'b1110);
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, 1, 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL got_restart%0d got %h exp %h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (Vs !== 1'b1) begin
            errors++; $display("FAIL got_vs_again got %b exp %b", Vs, 1'b1);
        end
    endtask

    task automatic test_error();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        checks++;
        if ({Bs, Error, bcd_10m, bcd_m, bcd_10s, bcd_s} !== 18'b01_0000_0000_0000_0000) begin
            errors++; $display("FAIL err_enter got %h exp %h", {Bs, Error, bcd_10m, bcd_m, bcd_10s, bcd_s}, 18'b01 << 16);
        end
        step(0, 0, 1, 1, 1, 0);
        checks++;
        if ({H, M, Error} !== 3'b011) begin
            errors++; $display("FAIL err_fill_ignored got %b exp %b", {H, M, Error}, 3'b011);
        end
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL err_exit got %h exp %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_fill_tick();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 19; i++) step(0, 1, 0, 1, 0, 0);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL fill_tick_pre got %h exp %h", dut_vec, exp_vec());
        end
        step(0, 1, 1, 1, 0, 0);
        checks++;
        if ({H, M, L, bcd_10m, bcd_m, bcd_10s, bcd_s} !== 19'b111_0000_0100_0000_0001) begin
            errors++; $display("FAIL fill_tick got %h exp %h", {H, M, L, bcd_10m, bcd_m, bcd_10s, bcd_s}, 19'b111_0000_0100_0000_0001);
        end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1, 0);
        checks++;
        if ({Vs, bcd_10m, bcd_m, bcd_10s, bcd_s} !== 17'h1_0701) begin
            errors++; $display("FAIL mid_pre got %h exp %h", {Vs, bcd_10m, bcd_m, bcd_10s, bcd_s}, 17'h1_0701);
        end
        step(1, 1, 1, 0, 1, 0);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL mid_reset got %h exp %h", dut_vec, exp_vec());
        end
    endtask

`ifdef IRRIG_PAUSE_EN
    task automatic test_pause();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 1, 0, 1);
            checks++;
            if ({Bs, bcd_10m, bcd_m, bcd_10s, bcd_s} !== 17'h1_0400) begin
                errors++; $display("FAIL pause%0d got %h exp %h", i, {Bs, bcd_10m, bcd_m, bcd_10s, bcd_s}, 17'h1_0400);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic a, g, p;
        a = 0; g = 0; p = 0;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) a = ~a;
            if ($urandom_range(0, 15) == 0) g = ~g;
            if ($urandom_range(0, 7) == 0) p = ~p;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 59) == 0, a, g, p);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL random%0d got %h exp %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_asp();
        test_got_empty();
        test_error();
        test_fill_tick();
        test_reset_mid();
`ifdef IRRIG_PAUSE_EN
        test_pause();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
